// File: rtl/lc3_mem_responder_if.sv
// Bus bundle between the LC3 core/testbench (master) and the memory responder (slave).
// Covers the fetch port, the data port and the preload port.
interface lc3_mem_responder_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic              instrmem_rd;
   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] Instr_dout;
   logic              complete_instr;
   logic              instr_err;

   logic              Data_rd;
   logic              Data_wr;
   logic [ADDR_W-1:0] Data_addr;
   logic [DATA_W-1:0] Data_din;
   logic [DATA_W-1:0] Data_dout;
   logic              complete_data;
   logic              data_err;

   logic              ld_en;
   logic              ld_sel;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_data;

   modport master (
      output instrmem_rd, pc, Data_rd, Data_wr, Data_addr, Data_din,
             ld_en, ld_sel, ld_addr, ld_data,
      input  Instr_dout, complete_instr, instr_err,
             Data_dout, complete_data, data_err
   );

   modport slave (
      input  instrmem_rd, pc, Data_rd, Data_wr, Data_addr, Data_din,
             ld_en, ld_sel, ld_addr, ld_data,
      output Instr_dout, complete_instr, instr_err,
             Data_dout, complete_data, data_err
   );
endinterface

// File: rtl/lc3_mem_responder.sv
// LC3 memory responder: separate instruction/data memories, each port with its own wait-state FSM.
// Optional MEM_LAT_JITTER_EN adds 0..3 LFSR-driven extra wait cycles per accepted request.
module lc3_mem_responder #(
   parameter int                DATA_W     = 16,
   parameter int                ADDR_W     = 16,
   parameter int                IMEM_DEPTH = 256,
   parameter int                DMEM_DEPTH = 1024,
   parameter logic [ADDR_W-1:0] IMEM_BASE  = 'h3000,
   parameter logic [ADDR_W-1:0] DMEM_BASE  = 'h0000,
   parameter int                INSTR_LAT  = 0,
   parameter int                DATA_LAT   = 0
) (
   input logic                clk,
   input logic                reset,
   lc3_mem_responder_if.slave bus
);

   localparam int                IMEM_AW  = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
   localparam int                DMEM_AW  = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
   localparam logic [ADDR_W-1:0] IMEM_LIM = ADDR_W'(IMEM_DEPTH);
   localparam logic [ADDR_W-1:0] DMEM_LIM = ADDR_W'(DMEM_DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   logic [DATA_W-1:0] imem [IMEM_DEPTH];
   logic [DATA_W-1:0] dmem [DMEM_DEPTH];

   // instruction port
   state_t            i_state, i_next;
   logic [4:0]        i_cnt, i_lat;
   logic [ADDR_W-1:0] i_addr, i_off;
   logic [DATA_W-1:0] i_hold, i_rd_val, i_dout;
   logic              i_accept, i_inrng, i_complete, i_err;

   // data port
   state_t            d_state, d_next;
   logic [4:0]        d_cnt, d_lat;
   logic [ADDR_W-1:0] d_addr, d_off;
   logic [DATA_W-1:0] d_din, d_hold, d_rd_val, d_dout;
   logic              d_rd, d_wr;
   logic              d_accept, d_inrng, d_commit, d_complete, d_err;

   // preload
   logic [ADDR_W-1:0] ld_i_off, ld_d_off;
   logic              ld_i_ok, ld_d_ok;

`ifdef MEM_LAT_JITTER_EN
   logic [7:0] lfsr;

   // Fibonacci x^8+x^6+x^5+x^4+1, free-running
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) lfsr <= 8'hA5;
      else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

   assign i_lat = 5'(INSTR_LAT) + {3'b000, lfsr[1:0]};
   assign d_lat = 5'(DATA_LAT)  + {3'b000, lfsr[3:2]};
`else
   assign i_lat = 5'(INSTR_LAT);
   assign d_lat = 5'(DATA_LAT);
`endif

   assign i_accept = (i_state == IDLE) && bus.instrmem_rd;
   assign d_accept = (d_state == IDLE) && (bus.Data_rd || bus.Data_wr);

   assign i_off    = i_addr - IMEM_BASE;
   assign i_inrng  = i_off < IMEM_LIM;
   assign i_rd_val = i_inrng ? imem[i_off[IMEM_AW-1:0]] : '0;

   assign d_off    = d_addr - DMEM_BASE;
   assign d_inrng  = d_off < DMEM_LIM;
   assign d_rd_val = d_inrng ? dmem[d_off[DMEM_AW-1:0]] : '0;
   // a rd/wr conflict is served as a read only
   assign d_commit = (d_state == DONE) && d_wr && !d_rd && d_inrng;

   assign ld_i_off = bus.ld_addr - IMEM_BASE;
   assign ld_d_off = bus.ld_addr - DMEM_BASE;
   assign ld_i_ok  = bus.ld_en && !bus.ld_sel && (ld_i_off < IMEM_LIM);
   assign ld_d_ok  = bus.ld_en &&  bus.ld_sel && (ld_d_off < DMEM_LIM);

   // ---------------- instruction FSM ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) i_state <= IDLE;
      else        i_state <= i_next;
   end

   always_comb begin
      i_next = i_state;
      case (i_state)
         IDLE:    if (bus.instrmem_rd) i_next = (i_lat == 5'd0) ? DONE : WAIT;
         WAIT:    if (i_cnt == 5'd1) i_next = DONE;
         DONE:    i_next = IDLE;
         default: i_next = IDLE;
      endcase
   end

   always_comb begin
      i_complete = 1'b0;
      i_err      = 1'b0;
      i_dout     = i_hold;
      if (i_state == DONE) begin
         i_complete = 1'b1;
         i_err      = !i_inrng;
         i_dout     = i_rd_val;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         i_cnt  <= '0;
         i_hold <= '0;
      end else begin
         if (i_accept)              i_cnt <= i_lat;
         else if (i_state == WAIT)  i_cnt <= i_cnt - 5'd1;
         if (i_state == DONE)       i_hold <= i_rd_val;
      end
   end

   always_ff @(posedge clk) begin
      if (i_accept) i_addr <= bus.pc;
   end

   // ---------------- data FSM ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) d_state <= IDLE;
      else        d_state <= d_next;
   end

   always_comb begin
      d_next = d_state;
      case (d_state)
         IDLE:    if (bus.Data_rd || bus.Data_wr) d_next = (d_lat == 5'd0) ? DONE : WAIT;
         WAIT:    if (d_cnt == 5'd1) d_next = DONE;
         DONE:    d_next = IDLE;
         default: d_next = IDLE;
      endcase
   end

   always_comb begin
      d_complete = 1'b0;
      d_err      = 1'b0;
      d_dout     = d_hold;
      if (d_state == DONE) begin
         d_complete = 1'b1;
         d_err      = !d_inrng || (d_rd && d_wr);
         if (d_rd) d_dout = d_rd_val;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         d_cnt  <= '0;
         d_hold <= '0;
         d_rd   <= 1'b0;
         d_wr   <= 1'b0;
      end else begin
         if (d_accept) begin
            d_cnt <= d_lat;
            d_rd  <= bus.Data_rd;
            d_wr  <= bus.Data_wr;
         end else if (d_state == WAIT) begin
            d_cnt <= d_cnt - 5'd1;
         end
         if (d_state == DONE && d_rd) d_hold <= d_rd_val;
      end
   end

   always_ff @(posedge clk) begin
      if (d_accept) begin
         d_addr <= bus.Data_addr;
         d_din  <= bus.Data_din;
      end
   end

   // ---------------- memories ----------------
   always_ff @(posedge clk) begin
      if (ld_i_ok) imem[ld_i_off[IMEM_AW-1:0]] <= bus.ld_data;
   end

   // port write is issued last so it overrides a same-word preload
   always_ff @(posedge clk) begin
      if (ld_d_ok)  dmem[ld_d_off[DMEM_AW-1:0]] <= bus.ld_data;
      if (d_commit) dmem[d_off[DMEM_AW-1:0]]    <= d_din;
   end

   assign bus.Instr_dout     = i_dout;
   assign bus.complete_instr = i_complete;
   assign bus.instr_err      = i_err;
   assign bus.Data_dout      = d_dout;
   assign bus.complete_data  = d_complete;
   assign bus.data_err       = d_err;

endmodule
